// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp: multi-port RV32 register file with two write ports, optional
// write-to-read bypass and a per-register busy scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int NRD    = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NRD*AW-1:0]   ra_i,
    output logic [NRD*XLEN-1:0] rd_o,
    output logic [NRD-1:0]      rbusy_o,
    input  logic                wea_i,
    input  logic [AW-1:0]       waa_i,
    input  logic [XLEN-1:0]     wda_i,
    input  logic                web_i,
    input  logic [AW-1:0]       wab_i,
    input  logic [XLEN-1:0]     wdb_i,
    input  logic                sb_set_i,
    input  logic [AW-1:0]       sb_addr_i,
    output logic                any_busy_o
);

    // Index 0 is never stored: the loops start at 1, so address 0 drops out.
    logic [XLEN-1:0] regs_q [NREG-1:1];
    logic [XLEN-1:0] regs_d [NREG-1:1];
    logic [NREG-1:1] busy_q;
    logic [NREG-1:1] busy_d;

    // Port B is applied after port A so it wins a collision; the set is last
    // so a newly issued producer supersedes a retiring one.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (wea_i && (waa_i == AW'(i))) begin
                regs_d[i] = wda_i;
                busy_d[i] = 1'b0;
            end
            if (web_i && (wab_i == AW'(i))) begin
                regs_d[i] = wdb_i;
                busy_d[i] = 1'b0;
            end
            if (sb_set_i && (sb_addr_i == AW'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    assign any_busy_o = |busy_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            hit_a;
        logic            hit_b;
        logic [XLEN-1:0] stored;
        logic            stored_busy;
        logic [XLEN-1:0] rd_p;
        logic            rbusy_p;

        assign ra    = ra_i[p*AW +: AW];
        assign hit_a = BYPASS && wea_i && (waa_i == ra);
        assign hit_b = BYPASS && web_i && (wab_i == ra);

        always_comb begin
            stored      = '0;
            stored_busy = 1'b0;
            for (int i = 1; i < NREG; i++) begin
                if (ra == AW'(i)) begin
                    stored      = regs_q[i];
                    stored_busy = busy_q[i];
                end
            end
        end

        // Reset gating keeps bypassed write data off the outputs while held.
        always_comb begin
            if (!rst_ni || (ra == '0)) begin
                rd_p = '0;
            end else if (hit_b) begin
                rd_p = wdb_i;
            end else if (hit_a) begin
                rd_p = wda_i;
            end else begin
                rd_p = stored;
            end
        end

        assign rbusy_p = rst_ni && stored_busy && !(hit_a || hit_b);

        assign rd_o[p*XLEN +: XLEN] = rd_p;
        assign rbusy_o[p]           = rbusy_p;
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// tb_regfile_mp: checks bypass and non-bypass builds against a register model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  ra = '0;
    logic        wea = 1'b0, web = 1'b0, sb_set = 1'b0;
    logic [4:0]  waa = '0, wab = '0, sb_addr = '0;
    logic [31:0] wda = '0, wdb = '0;

    logic [63:0] rd_b, rd_n;
    logic [1:0]  rbusy_b, rbusy_n;
    logic        any_b, any_n;

    int checks = 0;
    int failures = 0;

    bit [31:0] m_reg  [32];
    bit        m_busy [32];

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1'b1)) u_byp (
        .clk_i(clk), .rst_ni(rst_n), .ra_i(ra), .rd_o(rd_b), .rbusy_o(rbusy_b),
        .wea_i(wea), .waa_i(waa), .wda_i(wda), .web_i(web), .wab_i(wab), .wdb_i(wdb),
        .sb_set_i(sb_set), .sb_addr_i(sb_addr), .any_busy_o(any_b)
    );

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1'b0)) u_nob (
        .clk_i(clk), .rst_ni(rst_n), .ra_i(ra), .rd_o(rd_n), .rbusy_o(rbusy_n),
        .wea_i(wea), .waa_i(waa), .wda_i(wda), .web_i(web), .wab_i(wab), .wdb_i(wdb),
        .sb_set_i(sb_set), .sb_addr_i(sb_addr), .any_busy_o(any_n)
    );

    // Architectural model: storage and busy bits follow the write/issue rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  <= '0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            if (wea && waa != 0) begin m_reg[waa] <= wda; m_busy[waa] <= 1'b0; end
            if (web && wab != 0) begin m_reg[wab] <= wdb; m_busy[wab] <= 1'b0; end
            if (sb_set && sb_addr != 0) m_busy[sb_addr] <= 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 0) return '0;
        if (byp && web && wab == a) return wdb;
        if (byp && wea && waa == a) return wda;
        return m_reg[a];
    endfunction

    function automatic logic exp_rbusy(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 0) return 1'b0;
        return m_busy[a] && !(byp && ((wea && waa == a) || (web && wab == a)));
    endfunction

    function automatic logic exp_any();
        logic r = 1'b0;
        for (int i = 0; i < 32; i++) r = r | m_busy[i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            logic [4:0] a;
            a = ra[p*5 +: 5];
            chk($sformatf("rd_byp_p%0d", p), rd_b[p*32 +: 32], exp_rd(a, 1'b1));
            chk($sformatf("rd_nob_p%0d", p), rd_n[p*32 +: 32], exp_rd(a, 1'b0));
            chk($sformatf("rbusy_byp_p%0d", p), {31'd0, rbusy_b[p]}, {31'd0, exp_rbusy(a, 1'b1)});
            chk($sformatf("rbusy_nob_p%0d", p), {31'd0, rbusy_n[p]}, {31'd0, exp_rbusy(a, 1'b0)});
        end
        chk("any_byp", {31'd0, any_b}, {31'd0, exp_any()});
        chk("any_nob", {31'd0, any_n}, {31'd0, exp_any()});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wea = 1'b0; web = 1'b0; sb_set = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        rst_n = 1'b1;

        // Prior state, then async reset hides it.
        wea = 1; waa = 1; wda = 32'h0101_0101;
        web = 1; wab = 2; wdb = 32'h0202_0202;
        sb_set = 1; sb_addr = 1;
        tick(); idle();
        ra = {5'd2, 5'd1};
        #1 chk("pre_rd1", rd_b[31:0], 32'h0101_0101);
        chk("pre_rd2", rd_n[63:32], 32'h0202_0202);
        chk("pre_busy1", {31'd0, rbusy_b[0]}, 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("rst_rd", rd_b, 64'd0);
        chk("rst_rbusy", {30'd0, rbusy_b}, 32'd0);
        chk("rst_any", {31'd0, any_b}, 32'd0);

        // A write on an edge during reset is discarded.
        wea = 1; waa = 1; wda = 32'hDEAD_0000;
        tick(); idle();
        rst_n = 1'b1;
        #1 chk("rst_discard", rd_b[31:0], 32'd0);

        wea = 1; waa = 1; wda = 32'hAAAA_BBBB;
        tick(); idle();
        #1 chk("post_rst_wr", rd_b[31:0], 32'hAAAA_BBBB);

        // x0 is hardwired and never busy.
        wea = 1; waa = 0; wda = 32'hFFFF_FFFF; sb_set = 1; sb_addr = 0;
        tick(); idle();
        ra = '0;
        #1 chk("x0_rd", rd_b[31:0], 32'd0);
        chk("x0_busy", {31'd0, rbusy_b[0]}, 32'd0);
        chk("x0_any", {31'd0, any_b}, 32'd0);

        // Dual write collision and independent dual writes.
        wea = 1; waa = 5; wda = 32'h1111_1111;
        web = 1; wab = 5; wdb = 32'h2222_2222;
        tick(); idle();
        ra = {5'd0, 5'd5};
        #1 chk("collide", rd_n[31:0], 32'h2222_2222);
        wea = 1; waa = 6; wda = 32'h6666_6666;
        web = 1; wab = 7; wdb = 32'h7777_7777;
        tick(); idle();
        ra = {5'd7, 5'd6};
        #1 chk("dual_a", rd_n[31:0], 32'h6666_6666);
        chk("dual_b", rd_n[63:32], 32'h7777_7777);

        // Same-cycle bypass versus stored-only read.
        ra = {5'd0, 5'd3};
        wea = 1; waa = 3; wda = 32'h1234_5678;
        #1 chk("byp_early", rd_b[31:0], 32'h1234_5678);
        chk("nob_early", rd_n[31:0], 32'd0);
        tick(); idle();
        #1 chk("nob_late", rd_n[31:0], 32'h1234_5678);

        // Scoreboard set, set-wins-over-clear, then clear.
        sb_set = 1; sb_addr = 9;
        tick(); idle();
        ra = {5'd0, 5'd9};
        #1 chk("sb_set", {31'd0, rbusy_b[0]}, 32'd1);
        chk("sb_any", {31'd0, any_n}, 32'd1);
        web = 1; wab = 9; wdb = 32'h9999_0000; sb_set = 1; sb_addr = 9;
        #1 chk("sb_byp_hide", {31'd0, rbusy_b[0]}, 32'd0);
        chk("sb_nob_show", {31'd0, rbusy_n[0]}, 32'd1);
        tick(); idle();
        #1 chk("sb_setwins", {31'd0, rbusy_b[0]}, 32'd1);
        web = 1; wab = 9; wdb = 32'h9999_1111;
        tick(); idle();
        #1 chk("sb_clear", {31'd0, rbusy_n[0]}, 32'd0);
        chk("sb_any_clr", {31'd0, any_n}, 32'd0);

        // Mixed traffic, checked against the model every cycle.
        for (int k = 0; k < 80; k++) begin
            wea = 1'($urandom); waa = 5'($urandom_range(0, 15)); wda = $urandom;
            web = 1'($urandom); wab = 5'($urandom_range(0, 15)); wdb = $urandom;
            sb_set = 1'($urandom); sb_addr = 5'($urandom_range(0, 15));
            ra = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            tick();
        end
        idle();

        // Asynchronous reset between edges.
        wea = 1; waa = 4; wda = 32'hDEAD_BEEF; sb_set = 1; sb_addr = 4;
        tick(); idle();
        ra = {5'd0, 5'd4};
        #1 chk("mid_rd", rd_b[31:0], 32'hDEAD_BEEF);
        chk("mid_busy", {31'd0, rbusy_n[0]}, 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("mid_rst_rd", rd_n[31:0], 32'd0);
        chk("mid_rst_busy", {31'd0, rbusy_n[0]}, 32'd0);
        chk("mid_rst_any", {31'd0, any_n}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined RV32 core, replacing the single-write/dual-read file used by the single-cycle datapath. It provides NRD combinational read ports, two clocked write ports (ALU writeback and load writeback), optional same-cycle write-to-read bypass, and a per-register busy scoreboard for hazard detection in the issue stage. Register 0 is hardwired to zero and never busy.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥2)
- AW, $clog2(NREG), register address width (derived)
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = reads see same-cycle write data; 0 = reads see stored value only

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- RA  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- RD  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- RBUSY  out  NRD  busy flag for register addressed by each read port
- WEA  in  1  write enable, port A (ALU writeback)
- WAA  in  AW  write address, port A
- WDA  in  XLEN  write data, port A
- WEB  in  1  write enable, port B (load writeback)
- WAB  in  AW  write address, port B
- WDB  in  XLEN  write data, port B
- SB_SET  in  1  mark register SB_ADDR busy (instruction issued with that destination)
- SB_ADDR  in  AW  destination register being issued
- ANY_BUSY  out  1  OR of all busy bits (pipeline drain indicator)

## Operation
- Storage: NREG-1 registers of XLEN bits (index 0 not stored); busy vector of NREG-1 bits.
- Write: on rising CLK, if WEx and WAx≠0, reg[WAx] ← WDx. Both ports same nonzero address: port B wins. Writes to address 0 ignored.
- Read (combinational): RD[i] = 0 if RA[i]=0; else if BYPASS and WEB and WAB=RA[i] → WDB; else if BYPASS and WEA and WAA=RA[i] → WDA; else reg[RA[i]].
- Scoreboard clear: on rising CLK, any valid write (WEx, WAx≠0) clears busy[WAx].
- Scoreboard set: on rising CLK, SB_SET with SB_ADDR≠0 sets busy[SB_ADDR]. Set and clear to same register in one cycle: set wins (new producer supersedes old).
- RBUSY[i] = 0 if RA[i]=0; else busy[RA[i]] AND NOT (BYPASS and a valid write to RA[i] this cycle). With BYPASS=0 RBUSY reflects the stored bit only.
- ANY_BUSY = OR of stored busy bits (no bypass term).
- Widths: no arithmetic; addresses ≥ NREG impossible by construction (AW derived).

## Timing
- Reset: RST low immediately forces all registers to 0 and all busy bits to 0; RD all zero, RBUSY=0, ANY_BUSY=0 while asserted. Write or SB_SET coinciding with a CLK edge during reset is discarded. Release is synchronous in effect: first update on first rising edge with RST high.
- Write latency: 1 edge to storage; 0 cycles to RD when BYPASS=1.
- Read latency: combinational, 0 cycles.
- Busy: visible on RBUSY/ANY_BUSY the cycle after the SB_SET edge; cleared the cycle after the write edge (same cycle on RBUSY if BYPASS=1).
- Reset mid-operation: asynchronous assertion between edges clears state immediately; no partial write possible.

## Test plan
- Reset: RST=0 with RA={1,2} after prior writes → RD=0, RBUSY=0, ANY_BUSY=0; release, WEA=1 WAA=1 WDA=0xAAAABBBB, edge → RA0=1 reads 0xAAAABBBB.
- x0: WEA=1 WAA=0 WDA=0xFFFFFFFF and SB_SET=1 SB_ADDR=0, edge → RA=0 reads 0, RBUSY=0, ANY_BUSY=0.
- Dual write collision: WEA=1 WEB=1 both to reg 5, WDA=0x11111111 WDB=0x22222222, edge → reg 5 reads 0x22222222; WAA=6 WAB=7 same cycle → both written.
- Bypass: BYPASS=1, reg 3=0x0, WEA=1 WAA=3 WDA=0x12345678 before edge → RD for RA=3 already 0x12345678; BYPASS=0 build → 0x0 until after edge.
- Scoreboard: SB_SET reg 9, edge → RBUSY=1, ANY_BUSY=1; WEB to reg 9 with SB_SET reg 9 same edge → busy stays 1; next write to 9 alone → busy 0, ANY_BUSY 0.
- Async reset mid-cycle: busy[4]=1, reg 4=0xDEADBEEF, pull RST low between edges → RD=0, RBUSY=0 before next edge.
